// File: rtl/cv32e40x_pkg.sv
// Shared type definitions for the serial multiplier.
package cv32e40x_pkg;

    typedef enum logic [1:0] {
        MULS_MUL    = 2'b00,
        MULS_MULH   = 2'b01,
        MULS_MULHSU = 2'b10,
        MULS_MULHU  = 2'b11
    } mulser_opcode_e;

    typedef enum logic [1:0] {
        MULS_IDLE   = 2'b00,
        MULS_CALC   = 2'b01,
        MULS_FINISH = 2'b10
    } mulser_state_e;

endpackage

// File: rtl/cv32e40x_mult_serial.sv
// Shift-and-add 32x32 multiplier on operand magnitudes, one multiplier bit per cycle,
// with optional early termination and a valid/ready handshake on both sides.
module cv32e40x_mult_serial
    import cv32e40x_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  mulser_opcode_e operator_i,
    input  logic           data_ind_timing_i,
    input  logic [31:0]    op_a_i,
    input  logic [31:0]    op_b_i,
    input  logic           valid_i,
    output logic           ready_o,
    output logic           valid_o,
    input  logic           ready_i,
    output logic [31:0]    result_o
);

    mulser_state_e  state_q, state_d;
    mulser_opcode_e op_q;
    logic           dit_q;
    logic           neg_q;
    logic [63:0]    acc_q;
    logic [63:0]    mcand_q;
    logic [31:0]    mplier_q;
    logic [4:0]     cnt_q;

    logic           a_signed, b_signed, a_neg, b_neg;
    logic [31:0]    a_abs, b_abs;
    logic [63:0]    acc_sum;
    logic [31:0]    mplier_shr;
    logic [63:0]    prod;

    assign a_signed = (operator_i != MULS_MULHU);
    assign b_signed = (operator_i == MULS_MUL) || (operator_i == MULS_MULH);
    assign a_neg    = a_signed && op_a_i[31];
    assign b_neg    = b_signed && op_b_i[31];
    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    assign a_abs    = a_neg ? (~op_a_i + 32'd1) : op_a_i;
    assign b_abs    = b_neg ? (~op_b_i + 32'd1) : op_b_i;

    assign acc_sum    = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
    assign mplier_shr = mplier_q >> 1;

    assign prod     = neg_q ? (~acc_q + 64'd1) : acc_q;
    assign result_o = (op_q == MULS_MUL) ? prod[31:0] : prod[63:32];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= MULS_IDLE;
            op_q     <= MULS_MUL;
            dit_q    <= 1'b0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                MULS_IDLE: begin
                    if (valid_i) begin
                        op_q     <= operator_i;
                        dit_q    <= data_ind_timing_i;
                        neg_q    <= a_neg ^ b_neg;
                        acc_q    <= '0;
                        mcand_q  <= {32'd0, a_abs};
                        mplier_q <= b_abs;
                        cnt_q    <= '0;
                    end
                end
                MULS_CALC: begin
                    if (valid_i) begin
                        acc_q    <= acc_sum;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_shr;
                        cnt_q    <= cnt_q + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        if (!valid_i) begin
            ready_o = 1'b1;
            state_d = MULS_IDLE;
        end else begin
            case (state_q)
                MULS_IDLE:   state_d = MULS_CALC;
                MULS_CALC: begin
                    if ((cnt_q == 5'd31) || (!dit_q && (mplier_shr == 32'd0)))
                        state_d = MULS_FINISH;
                end
                MULS_FINISH: begin
                    valid_o = 1'b1;
                    if (ready_i) begin
                        ready_o = 1'b1;
                        state_d = MULS_IDLE;
                    end
                end
                default:     state_d = MULS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cv32e40x_mult_serial.sv
// Directed bench for the serial multiplier: results, latency, hold, kill and reset.
module tb_cv32e40x_mult_serial;
    import cv32e40x_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n;
    mulser_opcode_e operator_i;
    logic           data_ind_timing_i;
    logic [31:0]    op_a_i, op_b_i;
    logic           valid_i, ready_i;
    logic           ready_o, valid_o;
    logic [31:0]    result_o;

    int n_cmp = 0;
    int n_err = 0;

    cv32e40x_mult_serial dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .operator_i        (operator_i),
        .data_ind_timing_i (data_ind_timing_i),
        .op_a_i            (op_a_i),
        .op_b_i            (op_b_i),
        .valid_i           (valid_i),
        .ready_o           (ready_o),
        .valid_o           (valid_o),
        .ready_i           (ready_i),
        .result_o          (result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in cycle 0 (just after a clock edge); inputs are scrambled after cycle 0.
    task automatic run_op(input string tag, input mulser_opcode_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic dit, input logic [31:0] exp_res,
                          input int exp_lat, input int stall);
        int lat;
        logic [31:0] held;
        operator_i = op; op_a_i = a; op_b_i = b; data_ind_timing_i = dit;
        valid_i = 1'b1; ready_i = (stall == 0);
        #1;
        check({tag, "_c0_ready"}, 64'(ready_o), 64'd0);
        lat = 0;
        do begin
            tick();
            lat++;
            if (lat == 1) begin
                operator_i = MULS_MULHU; op_a_i = 32'hDEAD_BEEF;
                op_b_i = 32'h0BAD_F00D; data_ind_timing_i = ~dit;
            end
        end while (!valid_o && lat < 100);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, 64'(result_o), 64'(exp_res));
        held = result_o;
        for (int i = 0; i < stall; i++) begin
            check({tag, "_hold_ready"}, 64'(ready_o), 64'd0);
            tick();
            check({tag, "_hold_valid"}, 64'(valid_o), 64'd1);
            check({tag, "_hold_result"}, 64'(result_o), 64'(held));
        end
        ready_i = 1'b1;
        #1;
        check({tag, "_accept_ready"}, 64'(ready_o), 64'd1);
        tick();
        valid_i = 1'b0;
        #1;
        check({tag, "_idle_valid"}, 64'(valid_o), 64'd0);
        check({tag, "_idle_state"}, 64'(dut.state_q), 64'(MULS_IDLE));
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        operator_i = MULS_MUL; data_ind_timing_i = 1'b0; op_a_i = '0; op_b_i = '0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_result", 64'(result_o), 64'd0);
        check("rst_ready_vi0", 64'(ready_o), 64'd1);
        tick();

        run_op("mulhu_ff", MULS_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 33, 0);
        run_op("mul_m3x7", MULS_MUL, 32'hFFFF_FFFD, 32'd7, 1'b0, 32'hFFFF_FFEB, 4, 0);
        run_op("mul_m3x7_dit", MULS_MUL, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFEB, 33, 0);
        run_op("mulh_min", MULS_MULH, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 33, 0);
        run_op("mulhsu_ff", MULS_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 33, 0);
        run_op("mul_x0", MULS_MUL, 32'h0000_1234, 32'd0, 1'b0, 32'd0, 2, 0);
        run_op("mulh_neg", MULS_MULH, 32'hFFFF_FFFE, 32'd3, 1'b0, 32'hFFFF_FFFF, 3, 0);
        run_op("mul_big", MULS_MUL, 32'h0001_0000, 32'h0001_0001, 1'b0, 32'h0001_0000, 18, 0);
        run_op("mul_stall", MULS_MUL, 32'd100, 32'd5, 1'b0, 32'd500, 4, 3);

        // Kill a MULHU in cycle 5
        operator_i = MULS_MULHU; op_a_i = 32'hFFFF_FFFF; op_b_i = 32'hFFFF_FFFF;
        data_ind_timing_i = 1'b0; valid_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        valid_i = 1'b0;
        #1;
        check("kill_ready", 64'(ready_o), 64'd1);
        check("kill_valid", 64'(valid_o), 64'd0);
        tick();
        check("kill_state", 64'(dut.state_q), 64'(MULS_IDLE));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid_o) seen++;
            tick();
        end
        check("kill_no_valid", 64'(seen), 64'd0);
        run_op("mul_6x7", MULS_MUL, 32'd6, 32'd7, 1'b0, 32'd42, 4, 0);

        // Reset in the middle of an operation
        operator_i = MULS_MULHU; op_a_i = 32'hFFFF_FFFF; op_b_i = 32'hFFFF_FFFF;
        data_ind_timing_i = 1'b1; valid_i = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        rst_n = 1'b0; valid_i = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_state", 64'(dut.state_q), 64'(MULS_IDLE));
        check("midrst_result", 64'(result_o), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid_o) seen++;
            tick();
        end
        check("midrst_no_valid", 64'(seen), 64'd0);
        run_op("mulhsu_after", MULS_MULHSU, 32'hFFFF_FFFE, 32'h0000_0004, 1'b0, 32'hFFFF_FFFF, 4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cv32e40x_mult_serial.md
CV32E40X_MULT_SERIAL -- requirements
Module: cv32e40x_mult_serial

Interface
REQ-001 Parameters: none; all widths SHALL be fixed at 32-bit operands and a 64-bit internal product.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 operator_i  input  mulser_opcode_e  MULS_MUL, MULS_MULH, MULS_MULHSU or MULS_MULHU; sampled in MULS_IDLE only.
REQ-005 data_ind_timing_i  input  1  1 = fixed latency; 0 = early termination allowed; sampled in MULS_IDLE only.
REQ-006 op_a_i  input  32  multiplicand; sampled in MULS_IDLE only.
REQ-007 op_b_i  input  32  multiplier; sampled in MULS_IDLE only.
REQ-008 valid_i  input  1  request valid; low at any time kills the operation.
REQ-009 ready_o  output  1  request consumed or killed.
REQ-010 valid_o  output  1  result valid.
REQ-011 ready_i  input  1  consumer accepts result.
REQ-012 result_o  output  32  low product word for MULS_MUL; high product word otherwise.

Function
REQ-013 Signedness SHALL be: op_a signed for MUL, MULH, MULHSU; op_b signed for MUL and MULH; all other operands unsigned.
REQ-014 On init, |op_a| and |op_b| SHALL be latched as 32-bit unsigned, with 0x80000000 yielding 0x80000000, and neg_q SHALL be set to sign(a) XOR sign(b) of the signed operands.
REQ-015 The FSM SHALL have three states: MULS_IDLE, MULS_CALC and MULS_FINISH.
REQ-016 MULS_IDLE with valid_i=1 (cycle 0) SHALL load acc=0, mcand={32'b0,|a|}, mplier=|b|, cnt=0, latch operator and data_ind_timing, and go to MULS_CALC; ready_o=0, valid_o=0.
REQ-017 Each MULS_CALC cycle SHALL do acc += mcand when mplier[0]=1, then mcand <<= 1, mplier >>= 1 and cnt += 1.
REQ-018 MULS_CALC SHALL go to MULS_FINISH after the iteration with cnt=31, or, when latched data_ind_timing=0, after any iteration whose shifted mplier is 0.
REQ-019 The minimum number of MULS_CALC cycles SHALL be 1, including when op_b=0.
REQ-020 Latency: valid_o SHALL first assert in cycle 33 when data_ind_timing=1, and in cycle 1+max(1, msb_index(|b|)+1) when data_ind_timing=0.
REQ-021 In MULS_FINISH, valid_o=1 and result_o SHALL be the selected word of (neg_q ? -acc : acc) in 64-bit two's complement.
REQ-022 result_o and valid_o SHALL hold stable while ready_i=0.
REQ-023 In MULS_FINISH with ready_i=1, ready_o=1 and the next state SHALL be MULS_IDLE.
REQ-024 Kill: valid_i=0 in any state SHALL force ready_o=1, valid_o=0 and next state MULS_IDLE, overriding REQ-016..REQ-023.
REQ-025 A new request SHALL be accepted in the cycle after a kill or completion, with no internal state leaking from the previous operation.
REQ-026 All arithmetic SHALL wrap modulo 2^64, and the accumulator SHALL never overflow for 32x32 operands.

Reset
REQ-027 With rst_n=0 at a clock edge: state=MULS_IDLE, acc, mcand, mplier, cnt, neg_q and the latched operator SHALL all be 0.
REQ-028 After reset: valid_o=0 and result_o=0; ready_o SHALL equal !valid_i.
REQ-029 Reset asserted mid-operation SHALL abandon the operation without producing valid_o.

Structure
REQ-030 mulser_opcode_e and mulser_state_e SHALL be defined in cv32e40x_pkg.
REQ-031 Magnitude, adder, shifter and negation logic SHALL be inline, with no sub-module.
REQ-032 A single 64-bit adder SHALL be used; the final negation MAY share it or be separate.

Verification
REQ-033 MULHU 0xFFFFFFFF x 0xFFFFFFFF, dit=0 -> result_o 0xFFFFFFFE, valid_o at cycle 33.
REQ-034 MUL 0xFFFFFFFD (-3) x 7, dit=0 -> result_o 0xFFFFFFEB, valid_o at cycle 4; the same with dit=1 -> valid_o at cycle 33.
REQ-035 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-036 MUL 0x1234 x 0, dit=0 -> result_o 0, valid_o at cycle 2.
REQ-037 Kill: valid_i=0 at cycle 5 of MULHU -> ready_o=1 in that cycle, state MULS_IDLE next cycle, valid_o never asserts; the next MUL 6x7 -> result_o 42.
REQ-038 ready_i=0 for 3 cycles in MULS_FINISH -> valid_o and result_o stable; ready_o=1 only in the ready_i=1 cycle, then MULS_IDLE.
